// File: rtl/lvds_frame_sequencer.sv
// Buffers I/Q samples in a small FIFO and paces formatted LVDS frames onto serializer
// slot boundaries, with hold interval, underrun retry, CW mode, abort/flush and tail frames.
module lvds_frame_sequencer #(
    parameter int IQ_WIDTH    = 13,
    parameter int HOLD_FRAMES = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TAIL_FRAMES = 1,
    localparam int FRAME_W    = 2*IQ_WIDTH+6,
    localparam int LVL_W      = $clog2(FIFO_DEPTH)+1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_strobe,
    input  logic                start,
    input  logic                abort,
    input  logic                cw_mode,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [IQ_WIDTH-1:0] s_i,
    input  logic [IQ_WIDTH-1:0] s_q,
    input  logic                s_last,
    output logic [FRAME_W-1:0]  tx_data,
    output logic                busy,
    output logic                done,
    output logic [7:0]          underrun_count,
    output logic [LVL_W-1:0]    fifo_level
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int EW     = 2*IQ_WIDTH+1;
    localparam int CNT_W  = $clog2(HOLD_FRAMES+1);
    localparam int TAIL_W = $clog2(TAIL_FRAMES+1);

    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(HOLD_FRAMES-1);
    localparam logic [TAIL_W-1:0]   TAIL_MAX  = TAIL_W'(TAIL_FRAMES);
    localparam logic [IQ_WIDTH-1:0] CW_VAL    = {1'b0, {(IQ_WIDTH-1){1'b1}}};
    localparam logic [FRAME_W-1:0]  GAP_FRAME = '0;
    localparam logic [FRAME_W-1:0]  END_FRAME = {2'b10, {(IQ_WIDTH+1){1'b0}}, 2'b01, {(IQ_WIDTH+1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PREPARE, TRANSMIT, TAIL} state_t;

    function automatic logic [FRAME_W-1:0] data_frame(input logic [IQ_WIDTH-1:0] i_val,
                                                      input logic [IQ_WIDTH-1:0] q_val);
        return {2'b10, i_val, 1'b1, 2'b01, q_val, 1'b0};
    endfunction

    state_t             state, state_n;
    logic               frame_strobe_d, slot_q;
    logic               start_pend, abort_pend;
    logic               cw_lat, cw_n, last_lat, last_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [TAIL_W-1:0]  tail, tail_n;
    logic [FRAME_W-1:0] tx_n;
    logic               done_n, pop, under_inc, start_clr, abort_clr, flush;

    logic [EW-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [EW-1:0]      head;
    logic               push, fifo_empty;

    assign s_ready    = fifo_level < LVL_W'(FIFO_DEPTH);
    assign push       = s_valid & s_ready;
    assign fifo_empty = fifo_level == '0;
    assign head       = mem[rd_ptr];
    assign busy       = state != IDLE;

    // Sample storage carries no reset; validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s_last, s_i, s_q};
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // The slot edge is registered, so frame and state changes land one cycle after detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            tx_data        <= '0;
            cnt            <= '0;
            tail           <= '0;
            cw_lat         <= 1'b0;
            last_lat       <= 1'b0;
            done           <= 1'b0;
            underrun_count <= '0;
            frame_strobe_d <= 1'b0;
            slot_q         <= 1'b0;
            start_pend     <= 1'b0;
            abort_pend     <= 1'b0;
        end else begin
            state          <= state_n;
            tx_data        <= tx_n;
            cnt            <= cnt_n;
            tail           <= tail_n;
            cw_lat         <= cw_n;
            last_lat       <= last_n;
            done           <= done_n;
            frame_strobe_d <= frame_strobe;
            slot_q         <= frame_strobe & ~frame_strobe_d;
            if (under_inc && underrun_count != 8'hFF)
                underrun_count <= underrun_count + 8'd1;
            if (start_clr)                    start_pend <= 1'b0;
            else if (start && state == IDLE)  start_pend <= 1'b1;
            if (abort_clr)                    abort_pend <= 1'b0;
            else if (abort && state != IDLE)  abort_pend <= 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        tx_n      = tx_data;
        cnt_n     = cnt;
        tail_n    = tail;
        cw_n      = cw_lat;
        last_n    = last_lat;
        done_n    = 1'b0;
        pop       = 1'b0;
        under_inc = 1'b0;
        start_clr = 1'b0;
        abort_clr = 1'b0;
        flush     = 1'b0;
        if (slot_q) begin
            case (state)
                IDLE: begin
                    tx_n = GAP_FRAME;
                    if (start_pend) begin
                        start_clr = 1'b1;
                        cw_n      = cw_mode;
                        cnt_n     = '0;
                        state_n   = PREPARE;
                    end
                end
                PREPARE: begin
                    if (abort_pend) begin
                        tx_n    = END_FRAME;
                        tail_n  = TAIL_W'(1);
                        state_n = TAIL;
                    end else if (cnt != CNT_LAST) begin
                        tx_n  = GAP_FRAME;
                        cnt_n = cnt + CNT_W'(1);
                    end else if (cw_lat) begin
                        tx_n    = data_frame(CW_VAL, CW_VAL);
                        state_n = TRANSMIT;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        tx_n    = data_frame(head[2*IQ_WIDTH-1:IQ_WIDTH], head[IQ_WIDTH-1:0]);
                        last_n  = head[EW-1];
                        state_n = TRANSMIT;
                    end else begin
                        // Underrun: hold the counter so the next slot retries the pop.
                        tx_n      = GAP_FRAME;
                        under_inc = 1'b1;
                    end
                end
                TRANSMIT: begin
                    if (abort_pend || (!cw_lat && last_lat)) begin
                        tx_n    = END_FRAME;
                        tail_n  = TAIL_W'(1);
                        state_n = TAIL;
                    end else begin
                        tx_n    = GAP_FRAME;
                        cnt_n   = '0;
                        state_n = PREPARE;
                    end
                end
                TAIL: begin
                    if (tail < TAIL_MAX) begin
                        tx_n   = END_FRAME;
                        tail_n = tail + TAIL_W'(1);
                    end else begin
                        tx_n      = GAP_FRAME;
                        state_n   = IDLE;
                        done_n    = 1'b1;
                        abort_clr = 1'b1;
                        flush     = abort_pend;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule
